// File: rtl/dcache_ctrl_pkg.sv
// Shared definitions for the data-cache controller and its lines: bus widths,
// default burst length and the controller state encoding.
package dcache_ctrl_pkg;

    localparam int ADDRBITS   = 32;
    localparam int DATABITS   = 32;
    localparam int CACHEWORDS = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOOKUP = 3'd1,
        ST_FILL   = 3'd2,
        ST_WAIT   = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

endpackage

// File: rtl/dcache_victim_sel.sv
// Round-robin victim pointer with one-hot decode; advances once per fill.
module dcache_victim_sel #(
    parameter int NLINES = 4,
    parameter int LBITS  = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              advance_i,
    output logic [LBITS-1:0]  ptr_o,
    output logic [NLINES-1:0] onehot_o
);

    logic [LBITS-1:0] ptr_q;
    logic [LBITS-1:0] ptr_d;

    // NLINES is a power of two, so the natural LBITS-bit wrap is the modulo.
    assign ptr_d = advance_i ? ptr_q + 1'b1 : ptr_q;

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values of its peers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    always_comb begin
        onehot_o        = '0;
        onehot_o[ptr_q] = 1'b1;
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/dcache_ctrl.sv
// Data-cache controller: hit/miss detection across NLINES lines, round-robin
// fill sequencing and arbitration of the single memory-controller port.
module dcache_ctrl
    import dcache_ctrl_pkg::*;
#(
    parameter int NLINES   = 4,
    parameter int LBITS    = 2,
    parameter int BURSTLEN = CACHEWORDS
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         dcache_rdreq,
    input  logic                         dcache_wrreq,
    output logic [DATABITS-1:0]          dcache_dataout,
    output logic                         dcache_valid,
    input  logic [NLINES-1:0]            line_valid,
    input  logic [NLINES-1:0]            line_miss,
    input  logic [DATABITS*NLINES-1:0]   line_out,
    output logic [NLINES-1:0]            line_fill,
    input  logic [ADDRBITS*NLINES-1:0]   line_mem_addr,
    input  logic [NLINES-1:0]            line_mem_rdreq,
    input  logic [NLINES-1:0]            line_mem_wrreq,
    output logic [NLINES-1:0]            line_mem_valid,
    output logic [15:0]                  mem_burstlen,
    output logic [ADDRBITS-1:0]          mem_addr,
    output logic                         mem_rdreq,
    output logic                         mem_wrreq,
    input  logic                         mem_valid
);

    state_e                state_q;
    logic                  dcache_valid_q;
    logic [DATABITS-1:0]   dataout_q;
    logic [NLINES-1:0]     line_fill_q;
    logic [LBITS-1:0]      grant_q;
    logic                  grant_vld_q;
    logic                  abort_q;

    logic                  req;
    logic [LBITS-1:0]      victim_ptr;
    logic [NLINES-1:0]     victim_onehot;
    logic [DATABITS-1:0]   hit_data;
    logic [DATABITS-1:0]   grant_data;

    assign req = dcache_rdreq | dcache_wrreq;

    dcache_victim_sel #(
        .NLINES (NLINES),
        .LBITS  (LBITS)
    ) u_victim_sel (
        .clk       (clk),
        .reset_n   (reset_n),
        .advance_i (state_q == ST_FILL),
        .ptr_o     (victim_ptr),
        .onehot_o  (victim_onehot)
    );

    // Lowest-index hit wins when duplicate tags leave several lines valid.
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned and infers a latch.
    always_comb begin
        hit_data = '0;
        for (int i = NLINES - 1; i >= 0; i--) begin
            if (line_valid[i]) begin
                hit_data = line_out[DATABITS*i +: DATABITS];
            end
        end
    end

    // Memory port follows the granted line only; with no grant it idles at zero.
    always_comb begin
        grant_data     = '0;
        mem_addr       = '0;
        mem_rdreq      = 1'b0;
        mem_wrreq      = 1'b0;
        line_mem_valid = '0;
        for (int i = 0; i < NLINES; i++) begin
            if (int'(grant_q) == i) begin
                grant_data = line_out[DATABITS*i +: DATABITS];
                if (grant_vld_q) begin
                    mem_addr          = line_mem_addr[ADDRBITS*i +: ADDRBITS];
                    mem_rdreq         = line_mem_rdreq[i];
                    mem_wrreq         = line_mem_wrreq[i];
                    line_mem_valid[i] = mem_valid;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            dcache_valid_q <= 1'b0;
            dataout_q      <= '0;
            line_fill_q    <= '0;
            grant_q        <= '0;
            grant_vld_q    <= 1'b0;
            abort_q        <= 1'b0;
        end else begin
            dcache_valid_q <= 1'b0;
            line_fill_q    <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        state_q <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    // Neither hit nor full miss: lines are still settling, wait.
                    if (|line_valid) begin
                        dataout_q      <= hit_data;
                        dcache_valid_q <= 1'b1;
                        state_q        <= ST_DONE;
                    end else if (&line_miss) begin
                        line_fill_q <= victim_onehot;
                        abort_q     <= 1'b0;
                        state_q     <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    grant_q     <= victim_ptr;
                    grant_vld_q <= 1'b1;
                    if (!req) begin
                        abort_q <= 1'b1;
                    end
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (!req) begin
                        abort_q <= 1'b1;
                    end
                    // A dirty victim flushes first; the grant simply stays put.
                    if (line_valid[grant_q]) begin
                        dataout_q   <= grant_data;
                        grant_vld_q <= 1'b0;
                        if (req && !abort_q) begin
                            dcache_valid_q <= 1'b1;
                            state_q        <= ST_DONE;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign dcache_valid   = dcache_valid_q;
    assign dcache_dataout = dataout_q;
    assign line_fill      = line_fill_q;
    assign mem_burstlen   = 16'(BURSTLEN);

endmodule

// File: tb/tb_dcache_ctrl.sv
// Randomized self-checking bench for dcache_ctrl; the bench plays the cache
// lines and predicts victims, routing and read data from the controller rules.
module tb_dcache_ctrl;

    localparam int NLINES = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          dcache_rdreq;
    logic          dcache_wrreq;
    logic [31:0]   dcache_dataout;
    logic          dcache_valid;
    logic [3:0]    line_valid;
    logic [3:0]    line_miss;
    logic [127:0]  line_out;
    logic [3:0]    line_fill;
    logic [127:0]  line_mem_addr;
    logic [3:0]    line_mem_rdreq;
    logic [3:0]    line_mem_wrreq;
    logic [3:0]    line_mem_valid;
    logic [15:0]   mem_burstlen;
    logic [31:0]   mem_addr;
    logic          mem_rdreq;
    logic          mem_wrreq;
    logic          mem_valid;

    int n_checks = 0;
    int n_pass   = 0;
    int victim_m = 0;

    always #5 clk = ~clk;

    dcache_ctrl dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .dcache_rdreq   (dcache_rdreq),
        .dcache_wrreq   (dcache_wrreq),
        .dcache_dataout (dcache_dataout),
        .dcache_valid   (dcache_valid),
        .line_valid     (line_valid),
        .line_miss      (line_miss),
        .line_out       (line_out),
        .line_fill      (line_fill),
        .line_mem_addr  (line_mem_addr),
        .line_mem_rdreq (line_mem_rdreq),
        .line_mem_wrreq (line_mem_wrreq),
        .line_mem_valid (line_mem_valid),
        .mem_burstlen   (mem_burstlen),
        .mem_addr       (mem_addr),
        .mem_rdreq      (mem_rdreq),
        .mem_wrreq      (mem_wrreq),
        .mem_valid      (mem_valid)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic new_line_data();
        line_out      = {$urandom, $urandom, $urandom, $urandom};
        line_mem_addr = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic idle_inputs();
        dcache_rdreq   = 1'b0;
        dcache_wrreq   = 1'b0;
        line_valid     = '0;
        line_miss      = '0;
        line_mem_rdreq = '0;
        line_mem_wrreq = '0;
        mem_valid      = 1'b0;
    endtask

    // Expected read data on a hit: first valid line scanning upward from line 0.
    function automatic logic [31:0] first_hit(input logic [3:0] pattern, input logic [127:0] data);
        logic [31:0] r;
        logic        found;
        r = '0;
        found = 1'b0;
        for (int i = 0; i < NLINES; i++) begin
            if (pattern[i] && !found) begin
                r = data[32*i +: 32];
                found = 1'b1;
            end
        end
        return r;
    endfunction

    task automatic hit_txn(input logic is_wr, input logic [3:0] pattern);
        logic [31:0] exp;
        new_line_data();
        dcache_rdreq = !is_wr;
        dcache_wrreq = is_wr;
        tick();
        check("hit_early_valid", {31'd0, dcache_valid}, 32'd0);
        line_valid = pattern;
        line_miss  = ~pattern;
        exp = first_hit(pattern, line_out);
        tick();
        check("hit_valid", {31'd0, dcache_valid}, 32'd1);
        check("hit_no_fill", {28'd0, line_fill}, 32'd0);
        if (!is_wr) check("hit_data", dcache_dataout, exp);
        idle_inputs();
        tick();
        check("hit_strobe_len", {31'd0, dcache_valid}, 32'd0);
    endtask

    task automatic miss_txn(input logic is_wr, input logic abort, input int breather, input int nwait);
        logic [3:0]  vmask;
        logic [31:0] exp;
        new_line_data();
        vmask = 4'(1 << victim_m);
        dcache_rdreq = !is_wr;
        dcache_wrreq = is_wr;
        tick();
        for (int b = 0; b < breather; b++) begin
            line_valid = '0;
            line_miss  = 4'($urandom_range(0, 14));
            tick();
            check("lookup_stall_fill", {28'd0, line_fill}, 32'd0);
        end
        line_miss = '1;
        tick();
        check("fill_onehot", {28'd0, line_fill}, {28'd0, vmask});
        line_miss = '0;
        tick();
        check("fill_one_cycle", {28'd0, line_fill}, 32'd0);
        for (int k = 0; k < nwait; k++) begin
            if (abort && k == 0) begin
                dcache_rdreq = 1'b0;
                dcache_wrreq = 1'b0;
            end
            line_mem_addr  = {$urandom, $urandom, $urandom, $urandom};
            line_mem_rdreq = 4'($urandom);
            line_mem_wrreq = 4'($urandom);
            mem_valid      = 1'($urandom);
            line_valid     = 4'($urandom) & ~vmask;
            #1;
            check("route_addr", mem_addr, line_mem_addr[32*victim_m +: 32]);
            check("route_rdreq", {31'd0, mem_rdreq}, {31'd0, line_mem_rdreq[victim_m]});
            check("route_wrreq", {31'd0, mem_wrreq}, {31'd0, line_mem_wrreq[victim_m]});
            check("route_mvalid", {28'd0, line_mem_valid}, mem_valid ? {28'd0, vmask} : 32'd0);
            tick();
            check("wait_no_valid", {31'd0, dcache_valid}, 32'd0);
        end
        mem_valid  = 1'b0;
        line_valid = vmask | 4'($urandom);
        exp = line_out[32*victim_m +: 32];
        tick();
        if (abort) begin
            check("abort_no_strobe", {31'd0, dcache_valid}, 32'd0);
        end else begin
            check("miss_valid", {31'd0, dcache_valid}, 32'd1);
            if (!is_wr) check("miss_data", dcache_dataout, exp);
        end
        line_mem_rdreq = '1;
        line_mem_wrreq = '1;
        mem_valid      = 1'b1;
        #1;
        check("grant_drop_rd", {31'd0, mem_rdreq}, 32'd0);
        check("grant_drop_mv", {28'd0, line_mem_valid}, 32'd0);
        idle_inputs();
        victim_m = (victim_m + 1) % NLINES;
        tick();
        check("miss_strobe_len", {31'd0, dcache_valid}, 32'd0);
    endtask

    initial begin
        idle_inputs();
        line_out      = '0;
        line_mem_addr = '0;
        reset_n       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", {31'd0, dcache_valid}, 32'd0);
        check("rst_dataout", dcache_dataout, 32'd0);
        check("rst_fill", {28'd0, line_fill}, 32'd0);
        check("rst_mem_rd", {31'd0, mem_rdreq}, 32'd0);
        check("rst_mem_wr", {31'd0, mem_wrreq}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("burstlen", {16'd0, mem_burstlen}, 32'd8);
        reset_n = 1'b1;
        tick();

        // Cold read misses into line 0, then hits there; four more misses wrap.
        miss_txn(1'b0, 1'b0, 0, 2);
        hit_txn(1'b0, 4'b0001);
        miss_txn(1'b0, 1'b0, 1, 3);
        miss_txn(1'b0, 1'b0, 0, 4);
        miss_txn(1'b0, 1'b0, 0, 1);
        miss_txn(1'b0, 1'b0, 0, 2);
        check("wrap_victim", 32'(victim_m), 32'd1);
        hit_txn(1'b0, 4'b1010);
        hit_txn(1'b1, 4'b0100);

        for (int t = 0; t < 60; t++) begin
            if ($urandom_range(0, 1) == 0) begin
                hit_txn(1'($urandom), 4'($urandom_range(1, 15)));
            end else begin
                miss_txn(1'($urandom), $urandom_range(0, 5) == 0,
                         int'($urandom_range(0, 1)), int'($urandom_range(1, 4)));
            end
        end

        // Reset asserted while a fill is waiting on memory.
        new_line_data();
        dcache_rdreq = 1'b1;
        tick();
        line_miss = '1;
        tick();
        line_miss = '0;
        tick();
        line_mem_rdreq = '1;
        #1;
        check("pre_rst_route", {31'd0, mem_rdreq}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("arst_mem_rd", {31'd0, mem_rdreq}, 32'd0);
        check("arst_mem_addr", mem_addr, 32'd0);
        check("arst_fill", {28'd0, line_fill}, 32'd0);
        check("arst_valid", {31'd0, dcache_valid}, 32'd0);
        idle_inputs();
        victim_m = 0;
        tick();
        reset_n = 1'b1;
        tick();
        miss_txn(1'b0, 1'b0, 0, 2);
        hit_txn(1'b0, 4'b1000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
